// File: rtl/regfile_wb_arbiter_pkg.sv
// Shared constants and grant encoding for the register-file writeback arbiter.
// Used by regfile_wb_arbiter and wb_scoreboard.
package regfile_wb_arbiter_pkg;

  localparam int XLEN     = 32;
  localparam int NUM_REGS = 32;
  localparam int PTR_W    = $clog2(NUM_REGS);

  localparam logic [PTR_W-1:0] REG_ZERO = '0;

  typedef enum logic {
    GNT_EX  = 1'b0,
    GNT_LSU = 1'b1
  } gnt_e;

endpackage

// File: rtl/regfile_wb_arbiter_scoreboard.sv
// Busy scoreboard for registers with outstanding long-latency (load) writes.
// Produces a combinational hit when any issue operand is still pending.
module wb_scoreboard
  import regfile_wb_arbiter_pkg::*;
(
  input  logic             clk,
  input  logic             rst,
  input  logic             set_en,
  input  logic [PTR_W-1:0] set_ptr,
  input  logic             clr_en,
  input  logic [PTR_W-1:0] clr_ptr,
  input  logic [PTR_W-1:0] rs1,
  input  logic [PTR_W-1:0] rs2,
  input  logic [PTR_W-1:0] rd,
  output logic             hit
);

  logic [NUM_REGS-1:0] busy;
  logic [NUM_REGS-1:0] busy_nxt;

  // Clear is applied before set so a same-cycle set on the same register wins.
  always_comb begin
    busy_nxt = busy;
    if (clr_en) busy_nxt[clr_ptr] = 1'b0;
    if (set_en) busy_nxt[set_ptr] = 1'b1;
    busy_nxt[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) busy <= '0;
    else     busy <= busy_nxt;
  end

  assign hit = busy[rs1] | busy[rs2] | busy[rd];

endmodule

// File: rtl/regfile_wb_arbiter.sv
// Round-robin arbiter for the single regfile write port (EX vs LSU) plus issue stall.
// Optional conflict counter enabled by defining WBARB_STATS_EN.
module regfile_wb_arbiter
  import regfile_wb_arbiter_pkg::*;
(
  input  logic             i_CLK,
  input  logic             i_RST,
  input  logic             i_EX_VALID,
  input  logic [PTR_W-1:0] i_EX_RD,
  input  logic [XLEN-1:0]  i_EX_DATA,
  output logic             o_EX_READY,
  input  logic             i_LSU_VALID,
  input  logic [PTR_W-1:0] i_LSU_RD,
  input  logic [XLEN-1:0]  i_LSU_DATA,
  output logic             o_LSU_READY,
  input  logic             i_ISSUE_VALID,
  input  logic             i_ISSUE_LONG,
  input  logic [PTR_W-1:0] i_ISSUE_RD,
  input  logic [PTR_W-1:0] i_ISSUE_RS1,
  input  logic [PTR_W-1:0] i_ISSUE_RS2,
  output logic             o_ISSUE_STALL,
`ifdef WBARB_STATS_EN
  output logic [31:0]      o_CONFLICT_CNT,
`endif
  output logic             o_WE,
  output logic [PTR_W-1:0] o_RD_PTR,
  output logic [XLEN-1:0]  o_RD
);

  gnt_e last_grant;
  logic ex_fire;
  logic lsu_fire;
  logic sb_hit;
  logic sb_set;

  // When both request, the one that did not win last time is served.
  always_comb begin
    o_EX_READY  = i_EX_VALID  & (~i_LSU_VALID | (last_grant == GNT_LSU));
    o_LSU_READY = i_LSU_VALID & (~i_EX_VALID  | (last_grant == GNT_EX));
  end

  assign ex_fire  = i_EX_VALID  & o_EX_READY;
  assign lsu_fire = i_LSU_VALID & o_LSU_READY;

  always_ff @(posedge i_CLK) begin
    if (i_RST) begin
      o_WE       <= 1'b0;
      o_RD_PTR   <= '0;
      o_RD       <= '0;
      last_grant <= GNT_LSU;
    end else if (ex_fire) begin
      o_WE       <= (i_EX_RD != REG_ZERO);
      o_RD_PTR   <= i_EX_RD;
      o_RD       <= i_EX_DATA;
      last_grant <= GNT_EX;
    end else if (lsu_fire) begin
      o_WE       <= (i_LSU_RD != REG_ZERO);
      o_RD_PTR   <= i_LSU_RD;
      o_RD       <= i_LSU_DATA;
      last_grant <= GNT_LSU;
    end else begin
      o_WE <= 1'b0;
    end
  end

  assign o_ISSUE_STALL = i_ISSUE_VALID & sb_hit;
  assign sb_set = i_ISSUE_VALID & i_ISSUE_LONG & ~o_ISSUE_STALL & (i_ISSUE_RD != REG_ZERO);

  wb_scoreboard u_scoreboard (
    .clk     (i_CLK),
    .rst     (i_RST),
    .set_en  (sb_set),
    .set_ptr (i_ISSUE_RD),
    .clr_en  (lsu_fire),
    .clr_ptr (i_LSU_RD),
    .rs1     (i_ISSUE_RS1),
    .rs2     (i_ISSUE_RS2),
    .rd      (i_ISSUE_RD),
    .hit     (sb_hit)
  );

`ifdef WBARB_STATS_EN
  always_ff @(posedge i_CLK) begin
    if (i_RST)                         o_CONFLICT_CNT <= '0;
    else if (i_EX_VALID & i_LSU_VALID) o_CONFLICT_CNT <= o_CONFLICT_CNT + 32'd1;
  end
`endif

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
// Directed, table-driven bench for regfile_wb_arbiter.
module tb_regfile_wb_arbiter;
  import regfile_wb_arbiter_pkg::*;

  logic             clk = 1'b0;
  logic             rst;
  logic             ex_valid, lsu_valid, issue_valid, issue_long;
  logic [PTR_W-1:0] ex_rd, lsu_rd, issue_rd, issue_rs1, issue_rs2;
  logic [XLEN-1:0]  ex_data, lsu_data;
  logic             ex_ready, lsu_ready, issue_stall, we;
  logic [PTR_W-1:0] rd_ptr;
  logic [XLEN-1:0]  rd_data;
`ifdef WBARB_STATS_EN
  logic [31:0]      conflict_cnt;
`endif

  int n_total = 0;
  int n_pass  = 0;

  always #5 clk = ~clk;

  regfile_wb_arbiter dut (
    .i_CLK         (clk),
    .i_RST         (rst),
    .i_EX_VALID    (ex_valid),
    .i_EX_RD       (ex_rd),
    .i_EX_DATA     (ex_data),
    .o_EX_READY    (ex_ready),
    .i_LSU_VALID   (lsu_valid),
    .i_LSU_RD      (lsu_rd),
    .i_LSU_DATA    (lsu_data),
    .o_LSU_READY   (lsu_ready),
    .i_ISSUE_VALID (issue_valid),
    .i_ISSUE_LONG  (issue_long),
    .i_ISSUE_RD    (issue_rd),
    .i_ISSUE_RS1   (issue_rs1),
    .i_ISSUE_RS2   (issue_rs2),
    .o_ISSUE_STALL (issue_stall),
`ifdef WBARB_STATS_EN
    .o_CONFLICT_CNT(conflict_cnt),
`endif
    .o_WE          (we),
    .o_RD_PTR      (rd_ptr),
    .o_RD          (rd_data)
  );

  typedef struct {
    logic        ev;  logic [4:0] erd; logic [31:0] ed;
    logic        lv;  logic [4:0] lrd; logic [31:0] ld;
    logic        iv;  logic       il;
    logic [4:0]  ird; logic [4:0] irs1; logic [4:0] irs2;
    logic        x_er; logic x_lr; logic x_st; logic x_we; logic chk_bus;
    logic [4:0]  x_ptr; logic [31:0] x_data;
  } vec_t;

  vec_t vecs[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic idle_inputs();
    ex_valid = 0; ex_rd = 0; ex_data = 0;
    lsu_valid = 0; lsu_rd = 0; lsu_data = 0;
    issue_valid = 0; issue_long = 0; issue_rd = 0; issue_rs1 = 0; issue_rs2 = 0;
  endtask

  initial begin
    //          ev erd ed            lv lrd ld        iv il ird rs1 rs2  er lr st we cb ptr data
    vecs.push_back('{1, 5, 32'hDEADBEEF, 0, 0, 0,        0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 5, 32'hDEADBEEF});
    vecs.push_back('{0, 0, 0,            1, 6, 32'h66,   0, 0, 0, 0, 0,   0, 1, 0, 1, 1, 6, 32'h66});
    vecs.push_back('{1, 3, 32'h33,       1, 4, 32'h44,   0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 3, 32'h33});
    vecs.push_back('{1, 3, 32'h33,       1, 4, 32'h44,   0, 0, 0, 0, 0,   0, 1, 0, 1, 1, 4, 32'h44});
    vecs.push_back('{1, 3, 32'h33,       1, 4, 32'h44,   0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 3, 32'h33});
    vecs.push_back('{0, 0, 0,            0, 0, 0,        0, 0, 0, 0, 0,   0, 0, 0, 0, 1, 3, 32'h33});
    vecs.push_back('{0, 0, 0,            0, 0, 0,        1, 1, 7, 1, 2,   0, 0, 0, 0, 1, 3, 32'h33});
    vecs.push_back('{0, 0, 0,            0, 0, 0,        0, 0, 10, 7, 0,  0, 0, 0, 0, 1, 3, 32'h33});
    vecs.push_back('{0, 0, 0,            0, 0, 0,        1, 0, 10, 7, 0,  0, 0, 1, 0, 1, 3, 32'h33});
    vecs.push_back('{0, 0, 0,            1, 7, 32'h77,   1, 0, 10, 7, 0,  0, 1, 1, 1, 1, 7, 32'h77});
    vecs.push_back('{0, 0, 0,            0, 0, 0,        1, 0, 10, 7, 0,  0, 0, 0, 0, 1, 7, 32'h77});
    vecs.push_back('{0, 0, 0,            1, 9, 32'h99,   1, 1, 9, 1, 2,   0, 1, 0, 1, 1, 9, 32'h99});
    vecs.push_back('{0, 0, 0,            0, 0, 0,        1, 0, 11, 9, 0,  0, 0, 1, 0, 1, 9, 32'h99});
    vecs.push_back('{0, 0, 0,            0, 0, 0,        1, 0, 11, 3, 9,  0, 0, 1, 0, 1, 9, 32'h99});
    vecs.push_back('{0, 0, 0,            1, 9, 32'h98,   1, 0, 11, 9, 0,  0, 1, 1, 1, 1, 9, 32'h98});
    vecs.push_back('{0, 0, 0,            0, 0, 0,        1, 0, 11, 9, 0,  0, 0, 0, 0, 1, 9, 32'h98});
    vecs.push_back('{1, 0, 32'h1234,     0, 0, 0,        0, 0, 0, 0, 0,   1, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,            0, 0, 0,        1, 1, 0, 1, 2,   0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{0, 0, 0,            0, 0, 0,        1, 0, 5, 0, 0,   0, 0, 0, 0, 0, 0, 0});
    vecs.push_back('{1, 8, 32'h88,       0, 0, 0,        0, 0, 0, 0, 0,   1, 0, 0, 1, 1, 8, 32'h88});

    idle_inputs();
    rst = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    #3;
    chk("reset_we",    {31'd0, we}, 0);
    chk("reset_ptr",   {27'd0, rd_ptr}, 0);
    chk("reset_data",  rd_data, 0);
    chk("reset_stall", {31'd0, issue_stall}, 0);
`ifdef WBARB_STATS_EN
    chk("reset_cnt",   conflict_cnt, 0);
`endif
    @(posedge clk); #1;

    for (int i = 0; i < vecs.size(); i++) begin
      ex_valid = vecs[i].ev;  ex_rd = vecs[i].erd;  ex_data = vecs[i].ed;
      lsu_valid = vecs[i].lv; lsu_rd = vecs[i].lrd; lsu_data = vecs[i].ld;
      issue_valid = vecs[i].iv; issue_long = vecs[i].il; issue_rd = vecs[i].ird;
      issue_rs1 = vecs[i].irs1; issue_rs2 = vecs[i].irs2;
      #3;
      chk($sformatf("v%0d_ex_ready", i),  {31'd0, ex_ready},    {31'd0, vecs[i].x_er});
      chk($sformatf("v%0d_lsu_ready", i), {31'd0, lsu_ready},   {31'd0, vecs[i].x_lr});
      chk($sformatf("v%0d_stall", i),     {31'd0, issue_stall}, {31'd0, vecs[i].x_st});
      @(posedge clk); #1;
      chk($sformatf("v%0d_we", i), {31'd0, we}, {31'd0, vecs[i].x_we});
      if (vecs[i].chk_bus) begin
        chk($sformatf("v%0d_ptr", i),  {27'd0, rd_ptr}, {27'd0, vecs[i].x_ptr});
        chk($sformatf("v%0d_data", i), rd_data, vecs[i].x_data);
      end
    end
`ifdef WBARB_STATS_EN
    chk("conflict_cnt", conflict_cnt, 3);
`endif

    // Reset while x12 is busy and an LSU return to x12 is being granted.
    idle_inputs();
    issue_valid = 1; issue_long = 1; issue_rd = 12; issue_rs1 = 1; issue_rs2 = 2;
    @(posedge clk); #1;
    idle_inputs();
    issue_valid = 1; issue_rd = 13; issue_rs1 = 12;
    #3;
    chk("busy12_stall", {31'd0, issue_stall}, 1);
    @(posedge clk); #1;
    issue_valid = 0;
    lsu_valid = 1; lsu_rd = 12; lsu_data = 32'hC0C0;
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    idle_inputs();
    issue_valid = 1; issue_rd = 13; issue_rs1 = 12;
    #3;
    chk("midrst_we",    {31'd0, we}, 0);
    chk("midrst_ptr",   {27'd0, rd_ptr}, 0);
    chk("midrst_stall", {31'd0, issue_stall}, 0);
    @(posedge clk); #1;
    idle_inputs();
    @(posedge clk); #1;
    chk("midrst_we_after", {31'd0, we}, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
